pll_reset_sequencer: RTL and testbench
======================================

# pll_reset_sequencer

Sequences the system PLL from the 50 MHz reference clock. It drives the PLL reset, qualifies the asynchronous `locked` flag, and releases the video and CPU domain resets in a fixed order only after lock has been stable. Any later loss of lock re-asserts both resets and restarts the PLL. It sits between the board clock/reset pins and the PLL plus the downstream reset synchronizers in each clock domain.

## Interface
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 65536: cycles to wait for lock before retrying (≥2).
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release (≥1).
- `STAGE_GAP`, 64: cycles between video reset release and CPU reset release (≥1).
- `MAX_RETRY`, 7: retry budget, used only with `PLL_SEQ_FAULT_EN` (1..14).

- `clkin` in 1: 50 MHz reference clock; never a PLL output.
- `reset_n` in 1: synchronous, active-low reset.
- `locked` in 1: PLL lock flag, asynchronous to `clkin`.
- `pll_rst` out 1: PLL reset, active high.
- `video_reset_n` out 1: video-domain reset request, active low.
- `cpu_reset_n` out 1: CPU-domain reset request, active low.
- `ready` out 1: high in RUN only.
- `fault` out 1: retry budget exhausted.
- `retries` out 4: saturating count of restarts since `reset_n`.
- `state` out 3: current state code, for debug.

## Operation
- `locked` passes through a 2-flop synchronizer to give `locked_s`. Only `locked_s` is used.
- One shared down/up counter, sized for the largest parameter. It clears on every state entry.
- States and codes:
  - RESET=0: `pll_rst`=1. After RST_CYCLES cycles, go to WAIT_LOCK.
  - WAIT_LOCK=1: `pll_rst`=0. If `locked_s`=1, go to STABLE. If the counter reaches LOCK_TIMEOUT−1 with no lock, restart.
  - STABLE=2: if `locked_s`=0, restart. After STABLE_CYCLES consecutive high cycles, go to STAGE.
  - STAGE=3: `video_reset_n`=1. After STAGE_GAP cycles, go to RUN. If `locked_s`=0, restart.
  - RUN=4: `video_reset_n`=`cpu_reset_n`=`ready`=1. If `locked_s`=0, restart.
  - FAULT=5: only exists with the macro.
- A restart means: go to RESET and increment `retries`, saturating at 15.
- All outputs are registered and derived from the next state. On a restart, both resets re-assert and `ready` falls on the same edge that enters RESET.
- `reset_n`=0 forces RESET from any state, at any time, and clears `retries`. Mid-RUN reset therefore drops `ready`/`cpu_reset_n`/`video_reset_n` on the next edge.
- Downstream domains must re-synchronize `video_reset_n`/`cpu_reset_n` to their own clocks. This block does not.

## Timing
- Reset values: `pll_rst`=1, `video_reset_n`=0, `cpu_reset_n`=0, `ready`=0, `fault`=0, `retries`=0, `state`=0.
- `pll_rst` is high for exactly RST_CYCLES edges after the first edge with `reset_n`=1, including the edge with `reset_n` low → entry.
- Lock to video release: `locked` first sampled high at edge E. `locked_s` is high at E+1. STABLE is entered at E+2. `video_reset_n` rises at E+2+STABLE_CYCLES.
- `cpu_reset_n` and `ready` rise exactly STAGE_GAP edges after `video_reset_n`.
- Lock loss: `locked` first sampled low at edge L. The state is RESET and all resets are asserted at L+2, i.e. 2 cycles of synchronizer latency plus 1 registered edge.
- A lock pulse shorter than 2 cycles may be missed. This is acceptable.
- Timeout: from WAIT_LOCK entry, with no lock, RESET is re-entered after exactly LOCK_TIMEOUT cycles.

## Configuration
- `PLL_SEQ_FAULT_EN` defined:
  - A restart that would make `retries` exceed MAX_RETRY goes to FAULT instead.
  - In FAULT: `pll_rst`=1, both resets asserted, `fault`=1, `ready`=0.
  - FAULT is left only via `reset_n`=0.
- `PLL_SEQ_FAULT_EN` undefined:
  - Retries continue indefinitely.
  - `fault` is tied to 0 and state 5 is unreachable.

## Test plan
Parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, STAGE_GAP=3, MAX_RETRY=2.

- **Clean start.** Release `reset_n`. PLL model raises `locked` 20 cycles after `pll_rst` falls.
  - Required: `pll_rst` high for 4 cycles; `video_reset_n` rises 10 edges after `locked` is first sampled; `cpu_reset_n`/`ready` rise 3 edges later; `retries`=0.
- **Lock timeout.** `locked` held low.
  - Required: RESET re-entered every 104 cycles; `retries` goes 1, 2, ….
  - Undefined macro: `retries` saturates at 15 and `fault`=0.
- **Fault.** Same stimulus as lock timeout, with `PLL_SEQ_FAULT_EN` defined.
  - Required: third timeout enters FAULT with `fault`=1, `pll_rst`=1 and `state`=5.
  - Then `reset_n` pulse → `fault`=0, `retries`=0.
- **Glitch in STABLE.** `locked` drops for 3 cycles at STABLE cycle 5.
  - Required: RESET entered, `retries`=1, `video_reset_n` stays 0. Normal release follows on relock.
- **Loss in RUN.** Drop `locked` while in RUN.
  - Required: `ready`, `cpu_reset_n`, `video_reset_n` all 0 exactly 2 edges later; `pll_rst`=1; full resequence follows.
- **Reset mid-STAGE.** Assert `reset_n`=0 one cycle after `video_reset_n` rises.
  - Required: next edge shows all reset values, including `retries`=0.

Source files
------------

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL / downstream reset logic.
// master: sequencer side; slave: PLL model and reset consumers.
interface pll_reset_sequencer_if;
    // No valid/ready handshake here: ready is a level status, high only while
    // the sequencer sits in RUN, and every other output is a plain level too.
    logic       locked;
    logic       pll_rst;
    logic       video_reset_n;
    logic       cpu_reset_n;
    logic       ready;
    logic       fault;
    logic [3:0] retries;
    logic [2:0] state;

    modport master (
        input  locked,
        output pll_rst, video_reset_n, cpu_reset_n, ready, fault, retries, state
    );

    modport slave (
        output locked,
        input  pll_rst, video_reset_n, cpu_reset_n, ready, fault, retries, state
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, qualifies lock, then releases video and
// CPU resets in order. Optional macro PLL_SEQ_FAULT_EN adds a retry budget and a FAULT state.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGE_GAP     = 64,
    parameter int MAX_RETRY     = 7
) (
    input  logic            clkin,
    input  logic            reset_n,
    pll_reset_sequencer_if.master bus
);

    localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);

    if (RST_CYCLES < 1 || LOCK_TIMEOUT < 2 || STABLE_CYCLES < 1 || STAGE_GAP < 1 ||
        MAX_RETRY < 1 || MAX_RETRY > 14) begin : g_bad_param
        $error("pll_reset_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_STAGE     = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t        cur;
    state_t        nxt;
    logic          restart;
    logic          sync1;
    logic          locked_s;
    logic [CW-1:0] cnt;
    logic [3:0]    retries_q;

    logic pll_rst_d;
    logic video_d;
    logic cpu_d;
    logic ready_d;
    logic fault_d;

    // State register, shared cycle counter (cleared on every state entry) and retry count.
    always_ff @(posedge clkin) begin
        if (!reset_n) begin
            sync1     <= 1'b0;
            locked_s  <= 1'b0;
            cur       <= S_RESET;
            cnt       <= '0;
            retries_q <= 4'd0;
        end else begin
            sync1    <= bus.locked;
            locked_s <= sync1;
            cur      <= nxt;
            if (nxt != cur) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            if (restart && nxt == S_RESET && retries_q != 4'd15) begin
                retries_q <= retries_q + 4'd1;
            end
        end
    end

    always_comb begin
        nxt     = cur;
        restart = 1'b0;
        case (cur)
            S_RESET: begin
                if (cnt == RST_LAST) nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s)            nxt = S_STABLE;
                else if (cnt == TO_LAST) restart = 1'b1;
            end
            S_STABLE: begin
                if (!locked_s)               restart = 1'b1;
                else if (cnt == STABLE_LAST) nxt = S_STAGE;
            end
            S_STAGE: begin
                if (!locked_s)            restart = 1'b1;
                else if (cnt == GAP_LAST) nxt = S_RUN;
            end
            S_RUN: begin
                if (!locked_s) restart = 1'b1;
            end
`ifdef PLL_SEQ_FAULT_EN
            S_FAULT: begin
                nxt = S_FAULT;
            end
`endif
            default: begin
                nxt = S_RESET;
            end
        endcase

        if (restart) begin
`ifdef PLL_SEQ_FAULT_EN
            // A restart that would push retries past the budget parks in FAULT instead.
            if (retries_q >= 4'(MAX_RETRY)) nxt = S_FAULT;
            else                            nxt = S_RESET;
`else
            nxt = S_RESET;
`endif
        end
    end

    // Outputs decode the next state so they change on the same edge as the state.
    always_comb begin
        pll_rst_d = (nxt == S_RESET) || (nxt == S_FAULT);
        video_d   = (nxt == S_STAGE) || (nxt == S_RUN);
        cpu_d     = (nxt == S_RUN);
        ready_d   = (nxt == S_RUN);
`ifdef PLL_SEQ_FAULT_EN
        fault_d   = (nxt == S_FAULT);
`else
        fault_d   = 1'b0;
`endif
    end

    always_ff @(posedge clkin) begin
        if (!reset_n) begin
            bus.pll_rst       <= 1'b1;
            bus.video_reset_n <= 1'b0;
            bus.cpu_reset_n   <= 1'b0;
            bus.ready         <= 1'b0;
            bus.fault         <= 1'b0;
        end else begin
            bus.pll_rst       <= pll_rst_d;
            bus.video_reset_n <= video_d;
            bus.cpu_reset_n   <= cpu_d;
            bus.ready         <= ready_d;
            bus.fault         <= fault_d;
        end
    end

    assign bus.retries = retries_q;
    assign bus.state   = cur;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small parameters (4/100/8/3/2).
// Output word layout: {pll_rst, video_reset_n, cpu_reset_n, ready, fault, retries[3:0], state[2:0]}.
module tb_pll_reset_sequencer;

    logic clk;
    logic reset_n;

    pll_reset_sequencer_if bus ();

    pll_reset_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (100),
        .STABLE_CYCLES(8),
        .STAGE_GAP    (3),
        .MAX_RETRY    (2)
    ) dut (
        .clkin  (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] exp_q[$];

    typedef struct {
        logic        lk;
        int          cyc;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [11:0] mk(input logic p, input logic v, input logic c,
                                       input logic r, input logic f,
                                       input logic [3:0] ret, input logic [2:0] st);
        return {p, v, c, r, f, ret, st};
    endfunction

    function automatic logic [11:0] outs();
        return {bus.pll_rst, bus.video_reset_n, bus.cpu_reset_n, bus.ready, bus.fault,
                bus.retries, bus.state};
    endfunction

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        bus.locked = 1'b0;
        tick(2);
    endtask

    // scoreboard
    task automatic check_val(input string name, input logic [11:0] act, input logic [11:0] exp);
        logic [11:0] want;
        exp_q.push_back(exp);
        want = exp_q.pop_front();
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, act, want);
        end
    endtask

    task automatic check(input string name, input logic [11:0] exp);
        check_val(name, outs(), exp);
    endtask

    task automatic wait_video(input int max, output int n);
        n = 0;
        while (bus.video_reset_n !== 1'b1 && n < max) begin
            tick(1);
            n++;
        end
    endtask

    task automatic wait_ready(input int max, output int n);
        n = 0;
        while (bus.ready !== 1'b1 && n < max) begin
            tick(1);
            n++;
        end
    endtask

    int n;
    logic [3:0] ret_exp;

    initial begin
        // Clean start: lock raised so it is first sampled 20 edges after pll_rst falls (edge 4).
        tbl[0] = '{1'b0, 3,  mk(1,0,0,0,0,4'd0,3'd0), "rst_hold_e3"};
        tbl[1] = '{1'b0, 1,  mk(0,0,0,0,0,4'd0,3'd1), "pll_rst_fall_e4"};
        tbl[2] = '{1'b0, 19, mk(0,0,0,0,0,4'd0,3'd1), "wait_lock_e23"};
        tbl[3] = '{1'b1, 1,  mk(0,0,0,0,0,4'd0,3'd1), "lock_sampled_E"};
        tbl[4] = '{1'b1, 1,  mk(0,0,0,0,0,4'd0,3'd1), "sync_E1"};
        tbl[5] = '{1'b1, 1,  mk(0,0,0,0,0,4'd0,3'd2), "stable_entry_E2"};
        tbl[6] = '{1'b1, 7,  mk(0,0,0,0,0,4'd0,3'd2), "stable_E9"};
        tbl[7] = '{1'b1, 1,  mk(0,1,0,0,0,4'd0,3'd3), "video_rise_E10"};
        tbl[8] = '{1'b1, 2,  mk(0,1,0,0,0,4'd0,3'd3), "stage_E12"};
        tbl[9] = '{1'b1, 1,  mk(0,1,1,1,0,4'd0,3'd4), "run_E13"};

        do_reset();
        check("reset_values", mk(1,0,0,0,0,4'd0,3'd0));

        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.locked = tbl[i].lk;
            tick(tbl[i].cyc);
            check(tbl[i].name, tbl[i].exp);
        end

        // Loss in RUN: resets assert exactly two edges after locked is first sampled low.
        bus.locked = 1'b0;
        tick(1);
        check("run_loss_L", mk(0,1,1,1,0,4'd0,3'd4));
        tick(1);
        check("run_loss_L1", mk(0,1,1,1,0,4'd0,3'd4));
        tick(1);
        check("run_loss_L2", mk(1,0,0,0,0,4'd1,3'd0));
        bus.locked = 1'b1;
        wait_video(40, n);
        check_val("resequence_video_edges", 12'(n), 12'd13);
        wait_ready(10, n);
        check_val("resequence_ready_edges", 12'(n), 12'd3);
        check("resequence_run", mk(0,1,1,1,0,4'd1,3'd4));

        // Glitch in STABLE, then reset mid-STAGE.
        do_reset();
        reset_n    = 1'b1;
        bus.locked = 1'b1;
        tick(5);
        check("glitch_stable_entry", mk(0,0,0,0,0,4'd0,3'd2));
        tick(4);
        bus.locked = 1'b0;
        tick(2);
        check("glitch_stable_e11", mk(0,0,0,0,0,4'd0,3'd2));
        tick(1);
        bus.locked = 1'b1;
        check("glitch_restart", mk(1,0,0,0,0,4'd1,3'd0));
        wait_video(40, n);
        check_val("glitch_relock_video_edges", 12'(n), 12'd13);
        check("glitch_relock_stage", mk(0,1,0,0,0,4'd1,3'd3));
        reset_n = 1'b0;
        tick(1);
        check("reset_mid_stage", mk(1,0,0,0,0,4'd0,3'd0));

        // Lock timeout: RESET re-entered every 104 cycles.
        do_reset();
        reset_n = 1'b1;
        tick(103);
        check("timeout_wait_e103", mk(0,0,0,0,0,4'd0,3'd1));
        tick(1);
        check("timeout_1", mk(1,0,0,0,0,4'd1,3'd0));
`ifdef PLL_SEQ_FAULT_EN
        tick(104);
        check("timeout_2", mk(1,0,0,0,0,4'd2,3'd0));
        tick(104);
        check_val("fault_entry", {7'd0, bus.pll_rst, bus.fault, bus.state}, {7'd0, 1'b1, 1'b1, 3'd5});
        tick(120);
        check_val("fault_held", {7'd0, bus.pll_rst, bus.fault, bus.state}, {7'd0, 1'b1, 1'b1, 3'd5});
        reset_n = 1'b0;
        tick(1);
        check("fault_cleared", mk(1,0,0,0,0,4'd0,3'd0));
        reset_n = 1'b1;
`else
        for (int k = 2; k <= 16; k++) begin
            tick(104);
            ret_exp = (k > 15) ? 4'd15 : 4'(k);
            check($sformatf("timeout_%0d", k), mk(1,0,0,0,0,ret_exp,3'd0));
        end
`endif

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
